base64_stream_decode: RTL
=========================

Name: base64_stream_decode

Overview:
- Streaming Base64 decoder on the UART IoT receive path: accepts one ASCII character per handshake from the UART receiver and emits decoded bytes one per handshake.
- Inverse of the team's frame-wide Base64 encoder (6-bit groups → ASCII); this block turns ASCII back into 6-bit groups and then into bytes.
- Handles '=' padding, optional CR/LF skipping, flags malformed input, and counts decoded bytes per frame.

Parameters:
IGNORE_CRLF, 1, when 1 the characters 0x0D/0x0A are accepted and discarded without affecting the quantum; when 0 they are invalid
CNT_W, 16, width of decoded-byte counter (saturates at all-ones)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
clr  in  1  synchronous frame clear: aborts quantum, zeroes byte_cnt
in_valid  in  1  ASCII character valid
in_data  in  8  ASCII character
in_ready  out  1  decoder can accept a character
out_valid  out  1  decoded byte valid
out_data  out  8  decoded byte
out_ready  in  1  downstream accepts byte
out_last  out  1  qualifies out_data: final byte of a padded quantum (end of Base64 message)
err  out  1  one-cycle pulse: malformed input detected
byte_cnt  out  CNT_W  bytes emitted since reset/clr

Behaviour:
- Reset and clock are decided: one clock clk; rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset (rst_n=0 at a clk edge) and clr=1: state COLLECT, char count 0, accumulator 0, out_valid 0, out_last 0, err 0, in_ready 1. byte_cnt is 0 after rst_n or clr.
- rst_n takes priority over clr; clr takes priority over any handshake in the same cycle.
- Char map (combinational): 'A'-'Z'→0-25, 'a'-'z'→26-51, '0'-'9'→52-61, '+'→62, '/'→63, '='→pad, CR/LF→skip (if IGNORE_CRLF), else invalid.
- COLLECT state:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: skip chars change nothing.
  - A valid char shifts its 6 bits into a 24-bit accumulator at slot idx (0..3); idx increments.
  - A pad is legal only at idx 2 or 3.
  - After pad at idx 2, idx 3 must be pad; after any pad, no data char is allowed in the quantum.
  - Npad = 0/1/2 selects 3/2/1 output bytes.
  - On the 4th accepted slot: latch the byte count, go to EMIT next cycle.
- EMIT state:
  - in_ready=0, out_valid=1.
  - Bytes are presented MSB first (acc[23:16], [15:8], [7:0]).
  - Advance on out_valid&out_ready. out_data is held stable while out_ready=0.
  - out_last=1 on the final byte only if Npad>0.
  - After the final byte is accepted: idx=0, back to COLLECT in the next cycle.
- Latency: the 4th char is accepted at edge N; first byte is valid after edge N (same cycle as EMIT entry). Throughput ≤ 7 cycles per quantum with no backpressure.
- Error (invalid char, illegal pad placement, data after pad):
  - err=1 for exactly one cycle after the offending char is accepted.
  - Partial quantum discarded, idx=0, stay in COLLECT.
  - The offending char is consumed.
- Residual non-zero bits in padded quanta are ignored (lenient).
- byte_cnt increments per accepted output byte, saturating at 2^CNT_W-1.
- in_valid during EMIT is not consumed (in_ready=0). The upstream must hold the character.

Decomposition:
- Shared package base64_pkg holds:
  - state enum (COLLECT, EMIT)
  - char-class enum (DATA, PAD, SKIP, INVALID)
  - ASCII constants CHAR_PAD=0x3D, CHAR_CR=0x0D, CHAR_LF=0x0A
- One sub-module, base64_char_decode: combinational ASCII → {class, 6-bit value}, reusable by any future decoder. Top holds the FSM, accumulator, byte index, and counter.

Test Plan:
- "TWFu" with out_ready=1 → 0x4D,0x61,0x6E; out_last=0 throughout; byte_cnt=3; err never set.
- "TWE=" → 0x4D,0x61, out_last=1 on 0x61. "TQ==" → single 0x4D with out_last=1; byte_cnt=3 total.
- "TW*" followed by "TWFu":
  - err pulses one cycle after '*'; no bytes emitted for the partial quantum.
  - Then 0x4D,0x61,0x6E.
  - "T=" and "TW=u" → each raises err, no output.
- "TW\r\nFu" with IGNORE_CRLF=1 → 0x4D,0x61,0x6E. With IGNORE_CRLF=0 → err on 0x0D.
- Backpressure: "TWFu", out_ready low 5 cycles then toggled → out_data holds 0x4D while stalled; in_ready=0 throughout EMIT; bytes delivered in order, none lost or duplicated.
- Reset mid-EMIT: after 0x4D is accepted, drive rst_n=0 for one edge → out_valid=0, in_ready=1, byte_cnt=0. Next "TQ==" → 0x4D, out_last=1. clr mid-EMIT gives the same result.

Source files
------------

// File: rtl/base64_pkg.sv
// rtl/base64_pkg.sv - shared types and constants for the Base64 stream decoder
//
// Purpose: FSM state and character-class enums plus the ASCII constants that
//          the character decoder and the stream decoder both need.
// Ports:   none (package)

package base64_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DATA    = 2'd0,
        PAD     = 2'd1,
        SKIP    = 2'd2,
        INVALID = 2'd3
    } char_class_t;

    localparam logic [7:0] CHAR_PAD = 8'h3D;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;

endpackage

// File: rtl/base64_char_decode.sv
// rtl/base64_char_decode.sv - combinational ASCII to Base64 class/value map
//
// Purpose: classifies one ASCII character as data (with its 6-bit value),
//          pad '=', skippable CR/LF, or invalid.
// Ports:
//   i_char   in  8  ASCII character
//   o_class  out 2  char_class_t encoding (DATA, PAD, SKIP, INVALID)
//   o_value  out 6  6-bit group value, 0 unless o_class is DATA

module base64_char_decode
    import base64_pkg::*;
#(
    parameter bit IGNORE_CRLF = 1'b1
) (
    input  logic [7:0] i_char,
    output logic [1:0] o_class,
    output logic [5:0] o_value
);

    always_comb begin
        o_class = INVALID;
        o_value = 6'd0;
        if (i_char >= 8'h41 && i_char <= 8'h5A) begin
            o_class = DATA;
            o_value = 6'(i_char - 8'h41);           // 'A'..'Z' -> 0..25
        end else if (i_char >= 8'h61 && i_char <= 8'h7A) begin
            o_class = DATA;
            o_value = 6'(i_char - 8'h47);           // 'a'..'z' -> 26..51
        end else if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_class = DATA;
            o_value = 6'(i_char + 8'h04);           // '0'..'9' -> 52..61
        end else if (i_char == 8'h2B) begin
            o_class = DATA;
            o_value = 6'd62;
        end else if (i_char == 8'h2F) begin
            o_class = DATA;
            o_value = 6'd63;
        end else if (i_char == CHAR_PAD) begin
            o_class = PAD;
        end else if (IGNORE_CRLF && (i_char == CHAR_CR || i_char == CHAR_LF)) begin
            o_class = SKIP;
        end
    end

endmodule

// File: rtl/base64_stream_decode.sv
// rtl/base64_stream_decode.sv - streaming Base64 to byte decoder with pad/error handling
//
// Purpose: collects four Base64 characters into a 24-bit quantum, then emits
//          1..3 bytes MSB first; flags malformed input and counts bytes.
// Ports:
//   clk        in   1      system clock
//   rst_n      in   1      synchronous active-low reset
//   clr        in   1      synchronous frame clear (aborts quantum, zeroes byte_cnt)
//   in_valid   in   1      ASCII character valid
//   in_data    in   8      ASCII character
//   in_ready   out  1      decoder can accept a character (COLLECT)
//   out_valid  out  1      decoded byte valid (EMIT)
//   out_data   out  8      decoded byte
//   out_ready  in   1      downstream accepts byte
//   out_last   out  1      final byte of a padded quantum
//   err        out  1      one-cycle pulse after a malformed character is consumed
//   byte_cnt   out  CNT_W  bytes emitted since reset/clr, saturating

module base64_stream_decode
    import base64_pkg::*;
#(
    parameter bit IGNORE_CRLF = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             err,
    output logic [CNT_W-1:0] byte_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_idx;       // next slot in the quantum
    logic [23:0]       r_acc;
    logic [1:0]        r_npad;      // pads seen in this quantum
    logic [1:0]        r_bsel;      // byte being presented in EMIT
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic [1:0]        w_class_raw;
    char_class_t       w_class;
    logic [5:0]        w_value;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_bad;
    logic              w_done;
    logic              w_final_byte;

    base64_char_decode #(
        .IGNORE_CRLF (IGNORE_CRLF)
    ) u_char_decode (
        .i_char  (in_data),
        .o_class (w_class_raw),
        .o_value (w_value)
    );

    assign w_class    = char_class_t'(w_class_raw);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Npad = 0/1/2 means 3/2/1 bytes, so the last byte index is 2 - Npad.
    assign w_final_byte = (r_bsel == (2'd2 - r_npad));

    // Legality of the incoming character against the quantum built so far.
    always_comb begin
        w_bad  = 1'b0;
        w_done = 1'b0;
        unique case (w_class)
            DATA: begin
                w_bad  = (r_npad != 2'd0);
                w_done = (r_npad == 2'd0) && (r_idx == 2'd3);
            end
            PAD: begin
                w_bad  = (r_idx < 2'd2);
                w_done = (r_idx == 2'd3);
            end
            SKIP: begin
                w_bad  = 1'b0;
                w_done = 1'b0;
            end
            INVALID: begin
                w_bad  = 1'b1;
                w_done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            COLLECT: begin
                in_ready = 1'b1;
                if (w_in_fire && w_done) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (w_out_fire && w_final_byte) begin
                    w_state_nxt = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_idx  <= 2'd0;
            r_acc  <= 24'd0;
            r_npad <= 2'd0;
            r_bsel <= 2'd0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_err <= w_in_fire && w_bad;
            if (w_in_fire && w_class != SKIP) begin
                if (w_bad) begin
                    r_idx  <= 2'd0;
                    r_acc  <= 24'd0;
                    r_npad <= 2'd0;
                end else begin
                    // Pad slots load zero; leftover bits of padded quanta are never emitted.
                    unique case (r_idx)
                        2'd0: r_acc[23:18] <= (w_class == DATA) ? w_value : 6'd0;
                        2'd1: r_acc[17:12] <= (w_class == DATA) ? w_value : 6'd0;
                        2'd2: r_acc[11:6]  <= (w_class == DATA) ? w_value : 6'd0;
                        2'd3: r_acc[5:0]   <= (w_class == DATA) ? w_value : 6'd0;
                    endcase
                    r_idx <= r_idx + 2'd1;   // wraps to 0 on the 4th slot
                    if (w_class == PAD) begin
                        r_npad <= r_npad + 2'd1;
                    end
                end
            end
            if (w_out_fire) begin
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (w_final_byte) begin
                    r_bsel <= 2'd0;
                    r_npad <= 2'd0;
                    r_idx  <= 2'd0;
                    r_acc  <= 24'd0;
                end else begin
                    r_bsel <= r_bsel + 2'd1;
                end
            end
        end
    end

    always_comb begin
        out_data = r_acc[23:16];
        unique case (r_bsel)
            2'd0:    out_data = r_acc[23:16];
            2'd1:    out_data = r_acc[15:8];
            default: out_data = r_acc[7:0];
        endcase
    end

    assign out_last = (r_state == EMIT) && (r_npad != 2'd0) && w_final_byte;
    assign err      = r_err;
    assign byte_cnt = r_cnt;

endmodule
